// File: rtl/param_matrix_mult.sv
// Parameterised N x N unsigned matrix multiplier, C = A x B, one MAC per cycle.
// A and B are loaded element by element while idle. C is read back through a
// registered read port and can be read at any time.
module param_matrix_mult #(
  parameter int unsigned N   = 3,
  parameter int unsigned DW  = 16,
  parameter int unsigned SAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     load_we,
  input  logic                     load_sel,
  input  logic [$clog2(N*N)-1:0]   load_addr,
  input  logic [DW-1:0]            load_data,
  input  logic [$clog2(N*N)-1:0]   rd_addr,
  output logic [DW-1:0]            rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);

  localparam int unsigned AW = 2*DW + $clog2(N);
  localparam int unsigned IW = $clog2(N*N);
  localparam int unsigned NN = N*N;
  localparam int unsigned XW = $clog2(N);
  localparam logic [XW-1:0] LAST = XW'(N-1);
  localparam logic [AW-1:0] CMAX = {{(AW-DW){1'b0}}, {DW{1'b1}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

  state_t state, state_nx;

  logic [DW-1:0] a_mem [NN];
  logic [DW-1:0] b_mem [NN];
  logic [DW-1:0] c_mem [NN];

  logic [XW-1:0] i_q, j_q, k_q;
  logic [AW-1:0] acc;

  logic [IW-1:0] a_idx, b_idx, c_idx;
  logic [AW-1:0] sum;
  logic          sum_ovf;
  logic [DW-1:0] c_val;
  logic          k_last, j_last, i_last;
  logic          load_ok, rd_ok;
  logic          mac_en, start_go, c_we;

  // Operand addressing, MAC sum and the clamped/truncated value for C.
  always_comb begin
    a_idx   = IW'(i_q) * IW'(N) + IW'(k_q);
    b_idx   = IW'(k_q) * IW'(N) + IW'(j_q);
    c_idx   = IW'(i_q) * IW'(N) + IW'(j_q);
    sum     = acc + AW'(a_mem[a_idx]) * AW'(b_mem[b_idx]);
    sum_ovf = (sum > CMAX);
    c_val   = sum[DW-1:0];
    if (sum_ovf && (SAT != 0)) begin
      c_val = '1;
    end
    k_last  = (k_q == LAST);
    j_last  = (j_q == LAST);
    i_last  = (i_q == LAST);
    load_ok = (32'(load_addr) < NN);
    rd_ok   = (32'(rd_addr) < NN);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nx = state;
    mac_en   = 1'b0;
    start_go = 1'b0;
    c_we     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_go = 1'b1;
          state_nx = COMPUTE;
        end
      end
      COMPUTE: begin
        mac_en = 1'b1;
        c_we   = k_last;
        if (k_last && j_last && i_last) begin
          state_nx = FINISH;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand storage, loop indices, accumulator, C storage and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned e = 0; e < NN; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
        c_mem[e] <= '0;
      end
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
    end else begin
      busy    <= (state_nx != IDLE);
      done    <= (state_nx == FINISH);
      rd_data <= rd_ok ? c_mem[rd_addr] : '0;

      if ((state == IDLE) && load_we && load_ok) begin
        if (load_sel) begin
          b_mem[load_addr] <= load_data;
        end else begin
          a_mem[load_addr] <= load_data;
        end
      end

      if (start_go) begin
        i_q <= '0;
        j_q <= '0;
        k_q <= '0;
        acc <= '0;
        ovf <= 1'b0;
      end

      if (mac_en) begin
        if (c_we) begin
          c_mem[c_idx] <= c_val;
          if (sum_ovf) begin
            ovf <= 1'b1;
          end
          acc <= '0;
          k_q <= '0;
          if (j_last) begin
            j_q <= '0;
            i_q <= i_last ? '0 : i_q + XW'(1);
          end else begin
            j_q <= j_q + XW'(1);
          end
        end else begin
          acc <= sum;
          k_q <= k_q + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_param_matrix_mult.sv
// Bench for param_matrix_mult: four instances (N/DW/SAT variants) checked
// against a plain-arithmetic matrix product model.
module tb_param_matrix_mult;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  st, we;
  logic        sel;
  logic [3:0]  addr;
  logic [15:0] data;
  logic [3:0]  rd_addr;
  logic [15:0] rd0, rd3;
  logic [7:0]  rd1, rd2;
  logic [3:0]  busy, done, ovf;

  param_matrix_mult #(.N(3), .DW(16), .SAT(1)) u_d0 (
    .clk(clk), .reset(reset), .start(st[0]), .load_we(we[0]), .load_sel(sel),
    .load_addr(addr), .load_data(data), .rd_addr(rd_addr), .rd_data(rd0),
    .busy(busy[0]), .done(done[0]), .ovf(ovf[0]));

  param_matrix_mult #(.N(3), .DW(8), .SAT(1)) u_d1 (
    .clk(clk), .reset(reset), .start(st[1]), .load_we(we[1]), .load_sel(sel),
    .load_addr(addr), .load_data(data[7:0]), .rd_addr(rd_addr), .rd_data(rd1),
    .busy(busy[1]), .done(done[1]), .ovf(ovf[1]));

  param_matrix_mult #(.N(3), .DW(8), .SAT(0)) u_d2 (
    .clk(clk), .reset(reset), .start(st[2]), .load_we(we[2]), .load_sel(sel),
    .load_addr(addr), .load_data(data[7:0]), .rd_addr(rd_addr), .rd_data(rd2),
    .busy(busy[2]), .done(done[2]), .ovf(ovf[2]));

  param_matrix_mult #(.N(4), .DW(16), .SAT(1)) u_d3 (
    .clk(clk), .reset(reset), .start(st[3]), .load_we(we[3]), .load_sel(sel),
    .load_addr(addr), .load_data(data), .rd_addr(rd_addr), .rd_data(rd3),
    .busy(busy[3]), .done(done[3]), .ovf(ovf[3]));

  int checks = 0;
  int errors = 0;

  int nn  [4] = '{3, 3, 3, 4};
  int dw  [4] = '{16, 8, 8, 16};
  int sat [4] = '{1, 1, 0, 1};

  longint sa [4][64];
  longint sb [4][64];
  longint exp_c [64];
  bit     exp_ovf;
  longint got [64];

  // Reference: textbook matrix product, then clamp or wrap per element.
  function automatic void model(input int d);
    longint mx, s;
    int n;
    n = nn[d];
    mx = (longint'(1) << dw[d]) - 1;
    exp_ovf = 1'b0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += sa[d][r*n+k] * sb[d][k*n+c];
        if (s > mx) begin
          exp_ovf = 1'b1;
          exp_c[r*n+c] = (sat[d] != 0) ? mx : (s & mx);
        end else begin
          exp_c[r*n+c] = s;
        end
      end
    end
  endfunction

  function automatic longint rdv(input int d);
    case (d)
      0: return longint'(rd0);
      1: return longint'(rd1);
      2: return longint'(rd2);
      default: return longint'(rd3);
    endcase
  endfunction

  function automatic void clear_shadows();
    for (int d = 0; d < 4; d++)
      for (int e = 0; e < 64; e++) begin
        sa[d][e] = 0;
        sb[d][e] = 0;
      end
  endfunction

  task automatic load(input int d, input bit s, input int a, input longint v);
    @(negedge clk);
    we[d] = 1'b1; sel = s; addr = 4'(a); data = 16'(v);
    @(posedge clk);
    #1 we[d] = 1'b0;
    if (a < nn[d]*nn[d]) begin
      if (s) sb[d][a] = v & ((longint'(1) << dw[d]) - 1);
      else   sa[d][a] = v & ((longint'(1) << dw[d]) - 1);
    end
  endtask

  task automatic read_all(input int d);
    for (int idx = 0; idx < nn[d]*nn[d]; idx++) begin
      @(negedge clk);
      rd_addr = 4'(idx);
      @(negedge clk);
      got[idx] = rdv(d);
    end
  endtask

  // Pulses start (optionally with a B write in the same cycle) and watches the
  // run. Cycle e is the value presented to the e-th edge after the start edge.
  task automatic run(input int d, input int lw_addr, input longint lw_val,
                     input int we1, input int we2, input int st2, input int rstc,
                     output int dedge, output int ndone,
                     output bit b_first, output bit b_after, output bit b_rst);
    int n3;
    n3 = nn[d] * nn[d] * nn[d];
    dedge = -1; ndone = 0; b_first = 1'b0; b_after = 1'b1; b_rst = 1'b1;
    @(negedge clk);
    st[d] = 1'b1;
    if (lw_addr >= 0) begin
      we[d] = 1'b1; sel = 1'b1; addr = 4'(lw_addr); data = 16'(lw_val);
      sb[d][lw_addr] = lw_val & ((longint'(1) << dw[d]) - 1);
    end
    @(posedge clk);
    #1 st[d] = 1'b0; we[d] = 1'b0;
    for (int e = 1; e <= n3 + 8; e++) begin
      @(negedge clk);
      if (e == 1) b_first = busy[d];
      if (done[d]) begin
        ndone++;
        if (dedge < 0) dedge = e;
      end
      if (dedge > 0 && e == dedge + 1) b_after = busy[d];
      we[d] = (e == we1) || (e == we2);
      sel = 1'b0; addr = 4'd0; data = 16'hBEEF;
      st[d] = (e == st2);
      if (e == rstc) begin
        reset = 1'b1;
        clear_shadows();
        #1 b_rst = busy[d];
      end
      if (e == rstc + 1) reset = 1'b0;
    end
    we[d] = 1'b0; st[d] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 4'b0) begin errors++; $display("FAIL reset_busy got %b exp 0000", busy); end
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done got %b exp 0000", done); end
    checks++; if (ovf !== 4'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0000", ovf); end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rdv(d) !== 0) begin errors++; $display("FAIL reset_rd_data d%0d got %0d exp 0", d, rdv(d)); end
    end
    // Release and write A[0]=1 of the N=4 instance on the very first edge.
    reset = 1'b0;
    we[3] = 1'b1; sel = 1'b0; addr = 4'd0; data = 16'd1;
    sa[3][0] = 1;
    @(posedge clk);
    #1 we[3] = 1'b0;
    read_all(0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== 0) begin errors++; $display("FAIL reset_c[%0d] got %0d exp 0", i, got[i]); end
    end
  endtask

  task automatic test_directed();
    int av [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int bv [9] = '{1, 2, 3, 0, 1, 0, 0, 0, 1};
    int de, nd;
    bit bf, ba, br;
    for (int i = 0; i < 9; i++) load(0, 1'b0, i, av[i]);
    for (int i = 0; i < 9; i++) load(0, 1'b1, i, bv[i]);
    run(0, -1, 0, 0, 0, 0, 0, de, nd, bf, ba, br);
    checks++; if (de !== 28) begin errors++; $display("FAIL directed_done_edge got %0d exp 28", de); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL directed_done_count got %0d exp 1", nd); end
    checks++; if (bf !== 1'b1) begin errors++; $display("FAIL directed_busy_first got %0d exp 1", bf); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL directed_busy_after got %0d exp 0", ba); end
    model(0);
    read_all(0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_c[i]) begin errors++; $display("FAIL directed_c[%0d] got %0d exp %0d", i, got[i], exp_c[i]); end
    end
    checks++; if (ovf[0] !== exp_ovf) begin errors++; $display("FAIL directed_ovf got %0d exp %0d", ovf[0], exp_ovf); end
  endtask

  task automatic test_saturate();
    int de, nd;
    bit bf, ba, br;
    for (int d = 1; d <= 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        load(d, 1'b0, i, 255);
        load(d, 1'b1, i, 255);
      end
      run(d, -1, 0, 0, 0, 0, 0, de, nd, bf, ba, br);
      checks++; if (de !== 28) begin errors++; $display("FAIL sat_done_edge d%0d got %0d exp 28", d, de); end
      model(d);
      read_all(d);
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (got[i] !== exp_c[i]) begin errors++; $display("FAIL sat_c d%0d [%0d] got %0d exp %0d", d, i, got[i], exp_c[i]); end
      end
      checks++; if (ovf[d] !== 1'b1) begin errors++; $display("FAIL sat_ovf d%0d got %0d exp 1", d, ovf[d]); end
    end
  endtask

  task automatic test_random();
    int de, nd;
    bit bf, ba, br;
    longint v;
    for (int it = 0; it < 4; it++) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < 9; i++) begin
          v = (it % 2 == 1) ? longint'($urandom_range(0, 9)) : longint'($urandom & 32'hFFFF);
          load(d, 1'b0, i, v);
          v = (it % 2 == 1) ? longint'($urandom_range(0, 9)) : longint'($urandom & 32'hFFFF);
          if (i != 8) load(d, 1'b1, i, v);
        end
        // Out-of-range writes must leave storage untouched.
        load(d, 1'b0, 9 + int'($urandom_range(0, 6)), 16'hFFFF);
        load(d, 1'b1, 9 + int'($urandom_range(0, 6)), 16'hFFFF);
        v = (it % 2 == 1) ? longint'($urandom_range(0, 9)) : longint'($urandom & 32'hFFFF);
        run(d, 8, v, 0, 0, 0, 0, de, nd, bf, ba, br);
        checks++; if (de !== 28) begin errors++; $display("FAIL rand_done_edge it%0d d%0d got %0d exp 28", it, d, de); end
        model(d);
        read_all(d);
        for (int i = 0; i < 9; i++) begin
          checks++;
          if (got[i] !== exp_c[i]) begin errors++; $display("FAIL rand_c it%0d d%0d [%0d] got %0d exp %0d", it, d, i, got[i], exp_c[i]); end
        end
        checks++; if (ovf[d] !== exp_ovf) begin errors++; $display("FAIL rand_ovf it%0d d%0d got %0d exp %0d", it, d, ovf[d], exp_ovf); end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int de, nd;
    bit bf, ba, br;
    load(0, 1'b0, 0, 16'd3);
    for (int pass = 0; pass < 2; pass++) begin
      run(0, -1, 0, 5, 10, 7, 0, de, nd, bf, ba, br);
      checks++; if (de !== 28) begin errors++; $display("FAIL busy_done_edge p%0d got %0d exp 28", pass, de); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL busy_done_count p%0d got %0d exp 1", pass, nd); end
      model(0);
      read_all(0);
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (got[i] !== exp_c[i]) begin errors++; $display("FAIL busy_c p%0d [%0d] got %0d exp %0d", pass, i, got[i], exp_c[i]); end
      end
    end
  endtask

  task automatic test_n4();
    int de, nd;
    bit bf, ba, br;
    for (int i = 1; i < 16; i++) load(3, 1'b0, i, (i % 5 == 0) ? 1 : 0);
    for (int i = 0; i < 16; i++) load(3, 1'b1, i, i);
    run(3, -1, 0, 0, 0, 0, 0, de, nd, bf, ba, br);
    checks++; if (de !== 65) begin errors++; $display("FAIL n4_done_edge got %0d exp 65", de); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL n4_done_count got %0d exp 1", nd); end
    model(3);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (rd3 !== 16'(exp_c[i-1])) begin errors++; $display("FAIL n4_sweep[%0d] got %0d exp %0d", i-1, rd3, exp_c[i-1]); end
      end
      rd_addr = 4'(i);
    end
    checks++; if (ovf[3] !== 1'b0) begin errors++; $display("FAIL n4_ovf got %0d exp 0", ovf[3]); end
  endtask

  task automatic test_reset_midrun();
    int av [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int bv [9] = '{1, 2, 3, 0, 1, 0, 0, 0, 1};
    int de, nd;
    bit bf, ba, br;
    run(0, -1, 0, 0, 0, 0, 12, de, nd, bf, ba, br);
    checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_done_count got %0d exp 0", nd); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0d exp 0", br); end
    checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %0d exp 0", ovf[0]); end
    read_all(0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== 0) begin errors++; $display("FAIL midrst_c[%0d] got %0d exp 0", i, got[i]); end
    end
    for (int i = 0; i < 9; i++) load(0, 1'b0, i, av[i]);
    for (int i = 0; i < 9; i++) load(0, 1'b1, i, bv[i]);
    run(0, -1, 0, 0, 0, 0, 0, de, nd, bf, ba, br);
    checks++; if (de !== 28) begin errors++; $display("FAIL midrst_rerun_edge got %0d exp 28", de); end
    model(0);
    read_all(0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_c[i]) begin errors++; $display("FAIL midrst_rerun_c[%0d] got %0d exp %0d", i, got[i], exp_c[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; st = '0; we = '0; sel = 1'b0; addr = '0; data = '0; rd_addr = '0;
    clear_shadows();
    test_reset();
    test_directed();
    test_saturate();
    test_random();
    test_busy_ignore();
    test_n4();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_matrix_mult.md
PARAM_MATRIX_MULT -- requirements
Module: param_matrix_mult

Interface
REQ-001 Parameter N, default 3, matrix dimension (N x N square operands); legal range 2..8.
REQ-002 Parameter DW, default 16, element width of A, B and C (unsigned).
REQ-003 Parameter SAT, default 1; 1 = saturate each C element to DW bits, 0 = truncate to the low DW bits.
REQ-004 Localparam AW = 2*DW + clog2(N), accumulator width; localparam IW = clog2(N*N), element index width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin C = A x B.
REQ-008 load_we  input  1  element write strobe for A/B storage.
REQ-009 load_sel  input  1  write target; 0 = A, 1 = B.
REQ-010 load_addr  input  IW  row-major element index (row*N + col).
REQ-011 load_data  input  DW  element value to write.
REQ-012 rd_addr  input  IW  row-major index of the C element to read.
REQ-013 rd_data  output  DW  registered C[rd_addr]; valid one cycle after rd_addr is presented.
REQ-014 busy  output  1  high while computing.
REQ-015 done  output  1  one-cycle pulse when C is complete.
REQ-016 ovf  output  1  sticky flag; some C element exceeded 2^DW-1 during the last run.

Function
REQ-017 States: IDLE, COMPUTE, FINISH; reset enters IDLE.
REQ-018 IDLE: when load_we=1, write load_data to A or B at load_addr; addresses >= N*N ignored.
REQ-019 IDLE with start=1: capture, clear ovf, reset indices i=j=k=0 and the accumulator, and enter COMPUTE next cycle; load_we in the same cycle still takes effect before compute.
REQ-020 COMPUTE: exactly one MAC per cycle, acc += A[i][k]*B[k][j], unsigned, full AW-bit precision, no intermediate truncation.
REQ-021 Loop order: k innermost, then j, then i; when k = N-1, write the final sum to C[i][j], clear acc and advance j (wrapping j to 0 and advancing i at j = N-1).
REQ-022 C write: if sum > 2^DW-1, then SAT=1 stores 2^DW-1, SAT=0 stores sum[DW-1:0]; in both cases ovf is set.
REQ-023 After the MAC for i=j=k=N-1, enter FINISH; FINISH asserts done for exactly one cycle and returns to IDLE.
REQ-024 Latency: done is high in the cycle N^3+1 clock edges after the edge that sampled start (N=3: 28).
REQ-025 busy is 1 in COMPUTE and FINISH and 0 in IDLE; busy and done are both high in FINISH.
REQ-026 While busy: start is ignored (no restart, no queueing) and load_we is ignored (A/B unchanged).
REQ-027 rd_data is read from the C storage at any time; during COMPUTE it may show a partially updated C.
REQ-028 C keeps its values until the next start; ovf keeps its value until the next start or reset.

Reset
REQ-029 On asserting reset, the block enters IDLE immediately, including mid-COMPUTE, and the aborted run produces no done pulse.
REQ-030 Reset values: busy=0, done=0, ovf=0, rd_data=0, all A, B and C elements=0, indices and accumulator=0.
REQ-031 After release, the first rising edge is a normal IDLE cycle and accepts load_we or start.

Verification
REQ-032 N=3, DW=16: load A=[1 2 3;4 5 6;7 8 9], B=[1 2 3;0 1 0;0 0 1], then start -> done at edge 28; C=[1 4 6;4 13 18;7 22 30]; ovf=0.
REQ-033 N=3, DW=8, SAT=1, all A and B elements = 255 -> every C element = 255, ovf=1; same run with SAT=0 -> every C element = 3, ovf=1.
REQ-034 Pulse start again and apply load_we to A[0] at cycles 5 and 10 of the run -> no restart; A unchanged; done occurs once at edge 28.
REQ-035 Assert reset at cycle 12 of a run -> busy=0, C all 0, no done pulse; after reload and start, the correct result arrives at edge 28.
REQ-036 N=4, DW=16, A=identity, B[r][c]=r*4+c -> C equals B; done at edge 65; rd_addr sweep 0..15 returns 0..15 with one-cycle latency.
